// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch-unit bus bundle (imem read port, redirect input, decode handshake, halted flag)
interface instr_fetch_if;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        halted;
  modport master (
    output imem_en, imem_addr, if_valid, if_pc, if_instr, halted,
    input  imem_rdata, redirect_valid, redirect_pc, if_ready
  );
  modport slave (
    input  imem_en, imem_addr, if_valid, if_pc, if_instr, halted,
    output imem_rdata, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: pc register feeding a 2-entry {pc, instr} queue to decode, with redirect flush.
// Ports: clk, rst_n (async active-low); bus.master carries the imem read port (imem_en,
// imem_addr word index, imem_rdata same-cycle), redirect_valid/redirect_pc, the decode
// handshake (if_valid/if_ready/if_pc/if_instr) and halted.
// Optional FETCH_HALT_EN: stop fetching after pushing jal x0,0 until the next redirect.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input logic        clk,
  input logic        rst_n,
  instr_fetch_if.master bus
);
  logic [31:0] pc, h_pc, h_in, t_pc, t_in;
  logic [1:0]  cnt, tail;
  logic        run, pop, push, unused;
`ifdef FETCH_HALT_EN
  typedef enum logic {RUN, HALT} state_t;
  state_t state;
  assign run        = state == RUN;
  assign bus.halted = state == HALT;
`else
  assign run        = 1'b1;
  assign bus.halted = 1'b0;
`endif
  assign pop          = bus.if_valid & bus.if_ready;
  assign push         = run & ((cnt < 2'd2) | pop) & ~bus.redirect_valid;
  // Slot the new word lands in once this cycle's pop has shifted the queue.
  assign tail         = cnt - {1'b0, pop};
  assign bus.imem_en   = push;
  assign bus.imem_addr = {2'b00, pc[31:2]};
  assign bus.if_valid  = cnt != 2'd0;
  assign bus.if_pc     = bus.if_valid ? h_pc : 32'd0;
  assign bus.if_instr  = bus.if_valid ? h_in : 32'd0;
  assign unused        = ^bus.redirect_pc[1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc   <= RESET_PC;
      cnt  <= 2'd0;
      h_pc <= 32'd0;
      h_in <= 32'd0;
      t_pc <= 32'd0;
      t_in <= 32'd0;
`ifdef FETCH_HALT_EN
      state <= RUN;
`endif
    end else if (bus.redirect_valid) begin
      cnt <= 2'd0;
      pc  <= {bus.redirect_pc[31:2], 2'b00};
`ifdef FETCH_HALT_EN
      state <= RUN;
`endif
    end else begin
      if (pop) begin
        h_pc <= t_pc;
        h_in <= t_in;
      end
      if (push && tail == 2'd0) begin
        h_pc <= pc;
        h_in <= bus.imem_rdata;
      end
      if (push && tail == 2'd1) begin
        t_pc <= pc;
        t_in <= bus.imem_rdata;
      end
      if (push) pc <= pc + 32'd4;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
`ifdef FETCH_HALT_EN
      if (push && bus.imem_rdata == 32'h0000006f) state <= HALT;
`endif
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized scoreboard bench for instr_fetch against a queue-based model
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  instr_fetch_if bus();
  instr_fetch #(.RESET_PC(32'h0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct packed {logic [31:0] pc; logic [31:0] in;} ent_t;
  ent_t q[$];
  ent_t sb[$];
  logic [31:0] mpc;
  bit mhalt;
  int tests = 0;
  int fails = 0;
  int n78 = 0;
  function automatic logic [31:0] memf(input logic [31:0] w);
    case (w)
      32'd0:   return 32'h00404713;
      32'd1:   return 32'h00404693;
      32'd30:  return 32'h0000006f;
      default: return (w * 32'h9E3779B1) ^ 32'h13;
    endcase
  endfunction
  assign bus.imem_rdata = memf(bus.imem_addr);
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic mreset();
    q.delete();
    sb.delete();
    mpc = 32'h0;
    mhalt = 0;
  endtask
  task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
    bit pop, en;
    ent_t e;
    chk("if_valid", 32'(bus.if_valid), 32'(q.size() != 0));
    chk("if_pc", bus.if_pc, q.size() != 0 ? q[0].pc : 32'h0);
    chk("if_instr", bus.if_instr, q.size() != 0 ? q[0].in : 32'h0);
    chk("halted", 32'(bus.halted), 32'(mhalt));
    chk("imem_addr", bus.imem_addr, mpc >> 2);
    bus.if_ready = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    #1;
    pop = q.size() != 0 && rdy;
    en = !mhalt && (q.size() < 2 || pop) && !rv;
    chk("imem_en", 32'(bus.imem_en), 32'(en));
    if (rv) begin
      q.delete();
      sb.delete();
      mpc = rpc & 32'hFFFFFFFC;
      mhalt = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (en) begin
        e = '{mpc, memf(mpc >> 2)};
        q.push_back(e);
        sb.push_back(e);
`ifdef FETCH_HALT_EN
        if (e.in == 32'h0000006f) mhalt = 1;
`endif
        mpc = mpc + 32'd4;
      end
    end
    @(negedge clk);
  endtask
  always begin : monitor
    ent_t e;
    @(negedge clk);
    #2;
    if (rst_n && bus.if_valid && bus.if_ready && !bus.redirect_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_empty: got pop of pc %h expected no entry", bus.if_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", bus.if_pc, e.pc);
        chk("sb_instr", bus.if_instr, e.in);
        if (bus.if_pc == 32'h78) n78++;
      end
    end
  end
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_if_valid", 32'(bus.if_valid), 32'h0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    mreset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    bus.if_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    @(negedge clk);
    do_reset();
    step(1, 0, 0);
    chk("r34_valid", 32'(bus.if_valid), 32'h1);
    chk("r34_pc0", bus.if_pc, 32'h0);
    chk("r34_in0", bus.if_instr, 32'h00404713);
    step(1, 0, 0);
    chk("r34_pc1", bus.if_pc, 32'h4);
    chk("r34_in1", bus.if_instr, 32'h00404693);
    do_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    chk("r35_en", 32'(bus.imem_en), 32'h0);
    chk("r35_addr", bus.imem_addr, 32'h2);
    chk("r35_head", bus.if_pc, 32'h0);
    step(0, 0, 0);
    chk("r35_hold", bus.if_pc, 32'h0);
    step(1, 0, 0);
    chk("r35_pc4", bus.if_pc, 32'h4);
    step(1, 0, 0);
    chk("r35_pc8", bus.if_pc, 32'h8);
    step(0, 1, 32'h57);
    chk("r36_valid", 32'(bus.if_valid), 32'h0);
    chk("r36_addr", bus.imem_addr, 32'h15);
    step(0, 0, 0);
    chk("r36_pc", bus.if_pc, 32'h54);
    step(0, 0, 0);
    step(1, 1, 32'h100);
    chk("r37_valid", 32'(bus.if_valid), 32'h0);
    step(1, 0, 0);
    chk("r37_pc", bus.if_pc, 32'h100);
    step(1, 1, 32'hFFFFFFFC);
    step(1, 0, 0);
    chk("r38_top", bus.if_pc, 32'hFFFFFFFC);
    step(1, 0, 0);
    chk("r38_wrap", bus.if_pc, 32'h0);
`ifdef FETCH_HALT_EN
    n78 = 0;
    step(1, 1, 32'h70);
    repeat (8) step(1, 0, 0);
    chk("r39_once", 32'(n78), 32'h1);
    chk("r39_halted", 32'(bus.halted), 32'h1);
    chk("r39_en", 32'(bus.imem_en), 32'h0);
    step(1, 1, 32'h0);
    step(1, 0, 0);
    chk("r39_restart", bus.if_pc, 32'h0);
    chk("r39_run", 32'(bus.halted), 32'h0);
`endif
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      if (i == 1500) do_reset();
      t = $urandom_range(0, 1) ? (($urandom_range(0, 40) << 2) | $urandom_range(0, 3)) : $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, t);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
